serial_add_acc: RTL

- Bit-serial adder/accumulator datapath stage built on the rad-hard cell set; consumes the FA cell directly, with flops for the carry and shift registers.
- Takes a WIDTH-bit operand pair over a valid/ready handshake and adds one bit per clock through a single FA.
- Presents SUM/COUT over an output valid/ready handshake.
- Accumulate mode replaces operand B with the previous result, giving a minimal-area running sum for SEU-hardened control/telemetry counters.

---
 rtl/serial_add_pkg.sv | 29 ++
 rtl/rh_fa_cell.sv | 18 +
 rtl/serial_fa_slice.sv | 55 +++++
 rtl/serial_add_acc.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and helpers for the bit-serial adder/accumulator.
//   state_e       : controller states (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of a counter that indexes 0..w-1 (minimum 1 bit)
// ----------------------------------------------------------------------------
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 8;

   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned n;
      n = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < w) begin
            n = i + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/rh_fa_cell.sv
// ----------------------------------------------------------------------------
// rh_fa_cell
// Full-adder cell from the rad-hard library set (behavioural model).
//   A, B, CI : addend bits and carry-in
//   S, CO    : sum bit and carry-out
// ----------------------------------------------------------------------------
module rh_fa_cell (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   assign S  = A ^ B ^ CI;
   assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/serial_fa_slice.sv
// ----------------------------------------------------------------------------
// serial_fa_slice
// One-bit serial add slice: library FA cell plus the carry flop.
//   CLK, RESET_B : clock, asynchronous active-low reset (carry -> 0)
//   LOAD         : load CIN into the carry flop (start of an operation)
//   EN           : advance one bit, carry flop takes the FA carry-out
//   CIN          : carry-in for bit 0
//   A_BIT, B_BIT : current operand bits
//   S_BIT        : sum bit for the current position
//   CARRY        : registered carry (final carry once the last bit is done)
// ----------------------------------------------------------------------------
module serial_fa_slice (
   input  logic CLK,
   input  logic RESET_B,
   input  logic LOAD,
   input  logic EN,
   input  logic CIN,
   input  logic A_BIT,
   input  logic B_BIT,
   output logic S_BIT,
   output logic CARRY
);

   logic carry_q;
   logic carry_d;
   logic fa_co;

   rh_fa_cell u_fa (
      .A  (A_BIT),
      .B  (B_BIT),
      .CI (carry_q),
      .S  (S_BIT),
      .CO (fa_co)
   );

   always_comb begin
      carry_d = carry_q;
      if (LOAD) begin
         carry_d = CIN;
      end else if (EN) begin
         carry_d = fa_co;
      end
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end

   assign CARRY = carry_q;

endmodule

// File: rtl/serial_add_acc.sv
// ----------------------------------------------------------------------------
// serial_add_acc
// Bit-serial adder/accumulator: one FA, one bit per clock.
//   CLK, RESET_B        : clock, asynchronous active-low reset
//   IN_VALID / IN_READY : operand handshake (ready only in IDLE)
//   A, B, CIN           : operands and carry-in; B ignored when ACC_MODE=1
//   ACC_MODE            : 1 adds A to the accumulator, 0 adds A+B
//   OUT_VALID/OUT_READY : result handshake (valid only in DONE)
//   SUM, COUT           : last result and its carry-out (0 after reset)
// ----------------------------------------------------------------------------
module serial_add_acc
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET_B,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             ACC_MODE,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] opa_q,   opa_d;
   logic [WIDTH-1:0] opb_q,   opb_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic             acc_op_q, acc_op_d;
   logic             cout_q,  cout_d;

   logic fa_load;
   logic fa_en;
   logic fa_s;
   logic fa_carry;

   serial_fa_slice u_slice (
      .CLK     (CLK),
      .RESET_B (RESET_B),
      .LOAD    (fa_load),
      .EN      (fa_en),
      .CIN     (CIN),
      .A_BIT   (opa_q[0]),
      .B_BIT   (opb_q[0]),
      .S_BIT   (fa_s),
      .CARRY   (fa_carry)
   );

   // The result register shares storage with operand A: each sum bit enters
   // at the MSB as the consumed A bit leaves at the LSB, so after WIDTH
   // shifts opa holds the complete result.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sum_d    = sum_q;
      acc_d    = acc_q;
      acc_op_d = acc_op_q;
      cout_d   = cout_q;
      fa_load  = 1'b0;
      fa_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               opa_d    = A;
               opb_d    = ACC_MODE ? acc_q : B;
               acc_op_d = ACC_MODE;
               count_d  = '0;
               fa_load  = 1'b1;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            fa_en   = 1'b1;
            opa_d   = {fa_s, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == LAST_BIT) begin
               state_d = DONE;
               sum_d   = opa_d;
               if (acc_op_q) begin
                  acc_d = opa_d;
               end
            end
         end

         DONE: begin
            if (OUT_READY) begin
               // Keep the final carry visible once the slice carry is reused.
               cout_d  = fa_carry;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q  <= IDLE;
         count_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         sum_q    <= '0;
         acc_q    <= '0;
         acc_op_q <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sum_q    <= sum_d;
         acc_q    <= acc_d;
         acc_op_q <= acc_op_d;
         cout_q   <= cout_d;
      end
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign SUM       = sum_q;
   // In DONE the slice carry is frozen and holds the final carry; elsewhere
   // it is in use, so the held copy is presented instead.
   assign COUT      = (state_q == DONE) ? fa_carry : cout_q;

endmodule
